cabac_bae_stage2: RTL and testbench
===================================

# cabac_bae_stage2

Second stage of the CABAC binary arithmetic encoder. It consumes the per-bin LPS range and shift look-ups that stage 1 computes from the context state, and keeps the coder's range and low registers up to date. It handles regular, bypass and terminate bins, one bin per cycle. For each bin it emits the bits that renormalisation shifts out of low, together with a carry flag; the downstream bit-packing stage resolves carry propagation into earlier bits.

## Interface
Parameters: none.

- clk  input  1  clock
- rst  input  1  reset; one clock; asynchronous, active-high
- start_i  input  1  slice-start pulse; initialises range and low
- valid_i  input  1  bin present this cycle
- mode_i  input  2  bin type: 0 regular, 1 bypass, 2 terminate, 3 reserved (no-op)
- bin_i  input  1  bin value (bypass/terminate)
- bin_eq_lps_i  input  1  regular bin is LPS (from stage 1)
- range_lps_i  input  32  rLPS per qIdx; qIdx q at [8*(3-q)+7 : 8*(3-q)]
- range_lps_update_lut_i  input  36  rLPS<<shift, 9 b per qIdx; q at [9*(3-q)+8 : 9*(3-q)]
- shift_lut_i  input  16  LPS renorm shift per qIdx; q at [4*(3-q)+3 : 4*(3-q)]
- bits_valid_o  output  1  bits_o/bits_len_o/carry_o valid
- bits_o  output  10  emitted bits, right-aligned, MSB first
- bits_len_o  output  4  number of valid bits in bits_o (0..10)
- carry_o  output  1  add 1 to the last previously emitted bit
- range_o  output  9  current range register
- low_o  output  10  current low register
- done_o  output  1  one-cycle pulse after terminate bin 1
- bin_cnt_o  output  32  bins encoded since start_i (see Configuration)

## Operation
- FSM has two states: IDLE and ACTIVE.
  - Reset places the FSM in IDLE.
  - start_i moves it to ACTIVE from either state, sets range=510 and low=0, and ignores valid_i in that cycle.
  - A terminate bin with value 1 returns the FSM to IDLE.
  - valid_i is ignored while in IDLE.
- Regular bin (mode 0):
  - q = range[7:6]; rLPS = range_lps_i slice q; rMPS = range − rLPS.
  - LPS: sum = low + rMPS (11 b). range = update-lut slice q. n = shift slice q.
  - MPS: sum = low. If rMPS ≥ 256 then n = 0 and range = rMPS; otherwise n = 1 and range = rMPS<<1.
- Common update for regular bins:
  - carry = sum[10].
  - Emitted bits = sum[9:10−n]; none when n = 0.
  - low = (sum[9:0]<<n) truncated to 10 b.
- Bypass bin (mode 1):
  - s = {low,1'b0} + (bin_i ? range : 0), 12 b.
  - carry = s[11]; one bit emitted = s[10]; low = s[9:0]; range is unchanged.
- Terminate bin (mode 2): range −= 2.
  - bin 0: low is unchanged. If range < 256, range <<= 1, low <<= 1, and the shifted-out low[9] is emitted (n = 1).
  - bin 1: sum = low + range. Emit 10 bits {sum[9:1],1'b1} with carry = sum[10]. Then set range=510, low=0, pulse done_o, and go to IDLE.
- bits_valid_o asserts only when bits_len_o > 0 or carry_o = 1.
- mode 3 changes no state and produces no output.

## Timing
- All outputs are registered. Bits for a bin accepted at edge k appear during cycle k+1.
- range_o and low_o show the post-bin values from cycle k+1. Stage 1 uses these values for the next bin, so back-to-back bins run at one bin per clock.
- There is no backpressure: downstream must accept every bits_valid_o pulse.
- Reset values: range_o=510, low_o=0, bits_o=0, bits_len_o=0, carry_o=0, bits_valid_o=0, done_o=0, bin_cnt_o=0, FSM in IDLE.
- Reset asserted mid-slice: the in-flight bin is discarded and all outputs return to their reset values asynchronously.
- start_i and valid_i in the same cycle: start_i wins and the bin is dropped.

## Configuration
- CABAC_BAE_BIN_CNT_EN defined: bin_cnt_o increments on every accepted bin of modes 0–2 in ACTIVE, wraps at 2^32, and clears on start_i.
- Not defined: the counter logic is removed and bin_cnt_o is tied to 0.

## Test plan
- Reset then idle: range_o=510, low_o=0, bits_valid_o=0; valid_i pulses in IDLE change nothing.
- start_i, then regular MPS with range_lps_i=32'h80_b0_d0_f0: q=3, rLPS=240 → range_o=270, low_o=0, bits_valid_o=0.
- start_i, then regular LPS with the same LUT row, shift_lut_i=16'h1111, update-lut q3=480 → range_o=480, low_o=540, bits_o=0, bits_len_o=1, carry_o=0.
- From low=540, range=480, bypass bin 1 → bits_o=1, bits_len_o=1, carry_o=0, low_o=536, range_o=480.
- Bypass bin 1 reached via a bin sequence with low=900, range=300 → carry_o=1, bits_o=0, bits_len_o=1, low_o=52.
- start_i, then terminate bin 1 → bits_o=10'h1FD, bits_len_o=10, carry_o=0, done_o pulses once, FSM returns to IDLE. Assert rst during a following bin: all outputs return to reset values immediately.

Source files
------------

// File: rtl/cabac_bae_stage2.sv
// cabac_bae_stage2 - second stage of the CABAC binary arithmetic encoder.
//
// Holds the coder's range/low registers and processes one bin per clock.
// Bin types are regular, bypass and terminate. For each bin it registers the
// bits that renormalisation shifts out of low, plus a carry flag. Carry
// propagation into earlier bits is resolved by the downstream bit packer.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start_i                   slice start: range=510, low=0, FSM -> ACTIVE
//   valid_i, mode_i           bin strobe and type (0 reg, 1 byp, 2 term, 3 no-op)
//   bin_i, bin_eq_lps_i       bin value (byp/term), LPS flag (regular)
//   range_lps_i               rLPS per qIdx, 8 b each, q0 in the MSBs
//   range_lps_update_lut_i    rLPS<<shift per qIdx, 9 b each, q0 in the MSBs
//   shift_lut_i               LPS renorm shift per qIdx, 4 b each, q0 in the MSBs
//   bits_valid_o/bits_o/bits_len_o/carry_o  registered emitted bits
//   range_o, low_o            current coder registers
//   done_o                    one-cycle pulse after terminate bin 1
//   bin_cnt_o                 bins since start (only with the optional counter)
//
// Optional feature: define CABAC_BAE_BIN_CNT_EN to build the bin counter;
// otherwise bin_cnt_o is tied to 0.

module cabac_bae_stage2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        valid_i,
  input  logic [1:0]  mode_i,
  input  logic        bin_i,
  input  logic        bin_eq_lps_i,
  input  logic [31:0] range_lps_i,
  input  logic [35:0] range_lps_update_lut_i,
  input  logic [15:0] shift_lut_i,
  output logic        bits_valid_o,
  output logic [9:0]  bits_o,
  output logic [3:0]  bits_len_o,
  output logic        carry_o,
  output logic [8:0]  range_o,
  output logic [9:0]  low_o,
  output logic        done_o,
  output logic [31:0] bin_cnt_o
);

  localparam logic [8:0] RangeInit = 9'd510;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e      state_q, state_d;
  logic [8:0]  range_q, range_d;
  logic [9:0]  low_q, low_d;
  logic [9:0]  bits_q, bits_d;
  logic [3:0]  len_q, len_d;
  logic        carry_q, carry_d;
  logic        done_q, done_d;
  logic        bvalid_q;

  // Per-qIdx look-ups for the regular path
  logic [1:0]  q;
  logic [7:0]  r_lps;
  logic [8:0]  r_upd;
  logic [3:0]  lps_shift;
  logic [8:0]  r_mps;

  assign q = range_q[7:6];

  always_comb begin
    r_lps     = range_lps_i[7:0];
    r_upd     = range_lps_update_lut_i[8:0];
    lps_shift = shift_lut_i[3:0];
    unique case (q)
      2'd0: begin
        r_lps     = range_lps_i[31:24];
        r_upd     = range_lps_update_lut_i[35:27];
        lps_shift = shift_lut_i[15:12];
      end
      2'd1: begin
        r_lps     = range_lps_i[23:16];
        r_upd     = range_lps_update_lut_i[26:18];
        lps_shift = shift_lut_i[11:8];
      end
      2'd2: begin
        r_lps     = range_lps_i[15:8];
        r_upd     = range_lps_update_lut_i[17:9];
        lps_shift = shift_lut_i[7:4];
      end
      default: begin
        r_lps     = range_lps_i[7:0];
        r_upd     = range_lps_update_lut_i[8:0];
        lps_shift = shift_lut_i[3:0];
      end
    endcase
  end

  assign r_mps = range_q - {1'b0, r_lps};

  // Scratch values for each bin type
  logic [10:0] reg_sum;
  logic [3:0]  reg_n;
  logic [11:0] byp_sum;
  logic [8:0]  term_rng;
  logic [10:0] term_sum;

  always_comb begin
    state_d  = state_q;
    range_d  = range_q;
    low_d    = low_q;
    bits_d   = '0;
    len_d    = '0;
    carry_d  = 1'b0;
    done_d   = 1'b0;
    reg_sum  = '0;
    reg_n    = '0;
    byp_sum  = '0;
    term_rng = range_q - 9'd2;
    term_sum = '0;

    if (start_i) begin
      // start wins over a coincident bin, which is dropped
      state_d = StActive;
      range_d = RangeInit;
      low_d   = '0;
    end else if (state_q == StActive && valid_i) begin
      case (mode_i)
        2'd0: begin
          if (bin_eq_lps_i) begin
            reg_sum = {1'b0, low_q} + {2'b00, r_mps};
            range_d = r_upd;
            // More than 10 shifted bits cannot be represented on bits_o
            reg_n   = (lps_shift > 4'd10) ? 4'd10 : lps_shift;
          end else begin
            reg_sum = {1'b0, low_q};
            if (r_mps[8]) begin
              reg_n   = 4'd0;
              range_d = r_mps;
            end else begin
              reg_n   = 4'd1;
              range_d = {r_mps[7:0], 1'b0};
            end
          end
          carry_d = reg_sum[10];
          bits_d  = reg_sum[9:0] >> (4'd10 - reg_n);
          len_d   = reg_n;
          low_d   = reg_sum[9:0] << reg_n;
        end
        2'd1: begin
          byp_sum = {1'b0, low_q, 1'b0} + (bin_i ? {3'b000, range_q} : 12'd0);
          carry_d = byp_sum[11];
          bits_d  = {9'd0, byp_sum[10]};
          len_d   = 4'd1;
          low_d   = byp_sum[9:0];
        end
        2'd2: begin
          if (!bin_i) begin
            if (!term_rng[8]) begin
              range_d = {term_rng[7:0], 1'b0};
              low_d   = {low_q[8:0], 1'b0};
              bits_d  = {9'd0, low_q[9]};
              len_d   = 4'd1;
            end else begin
              range_d = term_rng;
            end
          end else begin
            // Final flush: 9 bits of low+range followed by the stop bit
            term_sum = {1'b0, low_q} + {2'b00, term_rng};
            bits_d   = {term_sum[9:1], 1'b1};
            len_d    = 4'd10;
            carry_d  = term_sum[10];
            range_d  = RangeInit;
            low_d    = '0;
            done_d   = 1'b1;
            state_d  = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      range_q  <= RangeInit;
      low_q    <= '0;
      bits_q   <= '0;
      len_q    <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      range_q  <= range_d;
      low_q    <= low_d;
      bits_q   <= bits_d;
      len_q    <= len_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      bvalid_q <= (len_d != 4'd0) || carry_d;
    end
  end

`ifdef CABAC_BAE_BIN_CNT_EN
  logic [31:0] cnt_q;
  logic        cnt_inc;

  assign cnt_inc = (state_q == StActive) && valid_i && !start_i && (mode_i != 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bin_cnt_o = cnt_q;
`else
  assign bin_cnt_o = '0;
`endif

  assign bits_valid_o = bvalid_q;
  assign bits_o       = bits_q;
  assign bits_len_o   = len_q;
  assign carry_o      = carry_q;
  assign range_o      = range_q;
  assign low_o        = low_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_cabac_bae_stage2.sv
// Directed bench for cabac_bae_stage2 with hand-computed expected values.

module tb_cabac_bae_stage2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        valid_i;
  logic [1:0]  mode_i;
  logic        bin_i;
  logic        bin_eq_lps_i;
  logic [31:0] range_lps_i;
  logic [35:0] range_lps_update_lut_i;
  logic [15:0] shift_lut_i;
  logic        bits_valid_o;
  logic [9:0]  bits_o;
  logic [3:0]  bits_len_o;
  logic        carry_o;
  logic [8:0]  range_o;
  logic [9:0]  low_o;
  logic        done_o;
  logic [31:0] bin_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cabac_bae_stage2 dut (
    .clk                    (clk),
    .rst                    (rst),
    .start_i                (start_i),
    .valid_i                (valid_i),
    .mode_i                 (mode_i),
    .bin_i                  (bin_i),
    .bin_eq_lps_i           (bin_eq_lps_i),
    .range_lps_i            (range_lps_i),
    .range_lps_update_lut_i (range_lps_update_lut_i),
    .shift_lut_i            (shift_lut_i),
    .bits_valid_o           (bits_valid_o),
    .bits_o                 (bits_o),
    .bits_len_o             (bits_len_o),
    .carry_o                (carry_o),
    .range_o                (range_o),
    .low_o                  (low_o),
    .done_o                 (done_o),
    .bin_cnt_o              (bin_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start_i = 1'b1;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic do_bin(input logic [1:0] m, input logic b, input logic lps);
    valid_i      = 1'b1;
    mode_i       = m;
    bin_i        = b;
    bin_eq_lps_i = lps;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic do_idle();
    valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    valid_i = 1'b0;
    mode_i = 2'd0;
    bin_i = 1'b0;
    bin_eq_lps_i = 1'b0;
    range_lps_i = 32'h80_b0_d0_f0;
    range_lps_update_lut_i = 36'h0_0000_01E0;
    shift_lut_i = 16'h1111;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_range", 32'(range_o), 510);
    chk("rst_low", 32'(low_o), 0);
    chk("rst_bvalid", 32'(bits_valid_o), 0);
    chk("rst_len", 32'(bits_len_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_cnt", bin_cnt_o, 0);
    rst = 1'b0;

    // Bins in IDLE are ignored
    do_bin(2'd1, 1'b1, 1'b0);
    chk("idle_low", 32'(low_o), 0);
    chk("idle_bvalid", 32'(bits_valid_o), 0);

    // Regular MPS, q=3, rLPS=240 -> rMPS=270, no renorm
    do_start();
    do_bin(2'd0, 1'b0, 1'b0);
    chk("mps_range", 32'(range_o), 270);
    chk("mps_low", 32'(low_o), 0);
    chk("mps_bvalid", 32'(bits_valid_o), 0);

    // Regular LPS: sum=270, range=480, n=1
    do_start();
    do_bin(2'd0, 1'b0, 1'b1);
    chk("lps_range", 32'(range_o), 480);
    chk("lps_low", 32'(low_o), 540);
    chk("lps_bits", 32'(bits_o), 0);
    chk("lps_len", 32'(bits_len_o), 1);
    chk("lps_carry", 32'(carry_o), 0);
    chk("lps_bvalid", 32'(bits_valid_o), 1);
`ifdef CABAC_BAE_BIN_CNT_EN
    chk("lps_cnt", bin_cnt_o, 1);
`endif

    // Bypass 1: s=1080+480=1560
    do_bin(2'd1, 1'b1, 1'b0);
    chk("byp_bits", 32'(bits_o), 1);
    chk("byp_len", 32'(bits_len_o), 1);
    chk("byp_carry", 32'(carry_o), 0);
    chk("byp_low", 32'(low_o), 536);
    chk("byp_range", 32'(range_o), 480);

    // Mode 3 is a no-op
    do_bin(2'd3, 1'b1, 1'b1);
    chk("nop_low", 32'(low_o), 536);
    chk("nop_range", 32'(range_o), 480);
    chk("nop_bvalid", 32'(bits_valid_o), 0);

    // Reach low=900, range=300: MPS (rLPS 210), bypass 1 -> 300, bypass 1 -> 900
    range_lps_i = 32'h3C_00_00_D2;
    do_start();
    do_bin(2'd0, 1'b0, 1'b0);
    chk("seq_mps_range", 32'(range_o), 300);
    do_bin(2'd1, 1'b1, 1'b0);
    chk("seq_byp1_low", 32'(low_o), 300);
    chk("seq_byp1_bvalid", 32'(bits_valid_o), 1);
    do_bin(2'd1, 1'b1, 1'b0);
    chk("seq_byp2_low", 32'(low_o), 900);
    // s=1800+300=2100 -> carry, bit 0, low 52
    do_bin(2'd1, 1'b1, 1'b0);
    chk("carry_carry", 32'(carry_o), 1);
    chk("carry_bits", 32'(bits_o), 0);
    chk("carry_len", 32'(bits_len_o), 1);
    chk("carry_low", 32'(low_o), 52);
    chk("carry_bvalid", 32'(bits_valid_o), 1);

    // Terminate 0 without renorm: range 298
    do_bin(2'd2, 1'b0, 1'b0);
    chk("term0_range", 32'(range_o), 298);
    chk("term0_low", 32'(low_o), 52);
    chk("term0_bvalid", 32'(bits_valid_o), 0);

    // MPS at q=0, rLPS=60 -> rMPS 238, renorm by one: range 476, low 104
    do_bin(2'd0, 1'b0, 1'b0);
    chk("mpsren_range", 32'(range_o), 476);
    chk("mpsren_low", 32'(low_o), 104);
    chk("mpsren_len", 32'(bits_len_o), 1);
    chk("mpsren_bits", 32'(bits_o), 0);

    // Terminate 1 right after start: sum=508 -> 0x1FD
    do_start();
    do_bin(2'd2, 1'b1, 1'b0);
    chk("term1_bits", 32'(bits_o), 32'h1FD);
    chk("term1_len", 32'(bits_len_o), 10);
    chk("term1_carry", 32'(carry_o), 0);
    chk("term1_done", 32'(done_o), 1);
    chk("term1_range", 32'(range_o), 510);
    chk("term1_low", 32'(low_o), 0);
    do_idle();
    chk("done_pulse", 32'(done_o), 0);
    // Back in IDLE: bypass bin is ignored
    do_bin(2'd1, 1'b1, 1'b0);
    chk("post_idle_low", 32'(low_o), 0);
    chk("post_idle_bvalid", 32'(bits_valid_o), 0);

    // start and valid together: bin dropped
    start_i = 1'b1;
    do_bin(2'd1, 1'b1, 1'b0);
    start_i = 1'b0;
    chk("startwin_low", 32'(low_o), 0);
    chk("startwin_bvalid", 32'(bits_valid_o), 0);

    // Bypass 1 from low 0, range 510 -> low 510; then async reset mid-cycle
    do_bin(2'd1, 1'b1, 1'b0);
    chk("prerst_low", 32'(low_o), 510);
    valid_i = 1'b1;
    mode_i  = 2'd1;
    bin_i   = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_low", 32'(low_o), 0);
    chk("arst_range", 32'(range_o), 510);
    chk("arst_bvalid", 32'(bits_valid_o), 0);
    chk("arst_len", 32'(bits_len_o), 0);
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
